// File: rtl/cm_event_scheduler.sv
// CM output event scheduler: serialises cfg/err/vga events with a quiet gap.
// Define CM_SCHED_RR_EN for cfg/vga round-robin; default is fixed err>cfg>vga.
module cm_event_scheduler #(
   parameter int CONFIG_STATUS_WIDTH       = 4,
   parameter int CONFIG_NOTIFICATION_WIDTH = 4,
   parameter int CONFIG_ERROR_WIDTH        = 4,
   parameter int VGA_NOTIFICATION_WIDTH    = 2,
   parameter int DATA_WIDTH                = 8,
   parameter int GAP_CYCLES                = 1
) (
   input  logic                                 clk,
   input  logic                                 rst,
   input  logic                                 cfg_valid,
   output logic                                 cfg_ready,
   input  logic [CONFIG_NOTIFICATION_WIDTH-1:0] cfg_code,
   input  logic                                 err_valid,
   output logic                                 err_ready,
   input  logic [CONFIG_ERROR_WIDTH-1:0]        err_code,
   input  logic                                 vga_valid,
   output logic                                 vga_ready,
   input  logic [VGA_NOTIFICATION_WIDTH-1:0]    vga_code,
   input  logic [DATA_WIDTH-1:0]                vga_data,
   input  logic                                 err_clr,
   output logic [CONFIG_STATUS_WIDTH-1:0]       Config_Status,
   output logic [CONFIG_NOTIFICATION_WIDTH-1:0] Config_Notification,
   output logic                                 Config_Notification_Valid,
   output logic [CONFIG_ERROR_WIDTH-1:0]        Config_Error,
   output logic                                 Error_Valid,
   output logic [VGA_NOTIFICATION_WIDTH-1:0]    VGA_Notification,
   output logic                                 VGA_Notification_Valid,
   output logic [DATA_WIDTH-1:0]                Data_VGA
);

   typedef enum logic {
      S_IDLE,
      S_GAP
   } state_t;

   localparam logic [1:0] SRC_CFG = 2'd1;
   localparam logic [1:0] SRC_ERR = 2'd2;
   localparam logic [1:0] SRC_VGA = 2'd3;

   localparam int GAP_LOAD_I = (GAP_CYCLES == 0) ? 0 : GAP_CYCLES - 1;
   localparam logic [3:0] GAP_LOAD = GAP_LOAD_I[3:0];

   state_t state_q;
   logic [3:0] gap_cnt_q;

   logic cfg_full_q, err_full_q, vga_full_q;
   logic cfg_full_d, err_full_d, vga_full_d;
   logic cfg_rdy_q, err_rdy_q, vga_rdy_q;
   logic [CONFIG_NOTIFICATION_WIDTH-1:0] cfg_code_q;
   logic [CONFIG_ERROR_WIDTH-1:0] err_code_q;
   logic [VGA_NOTIFICATION_WIDTH-1:0] vga_code_q;
   logic [DATA_WIDTH-1:0] vga_data_q;

   logic [CONFIG_NOTIFICATION_WIDTH-1:0] cfg_out_q;
   logic [CONFIG_ERROR_WIDTH-1:0] err_out_q;
   logic [VGA_NOTIFICATION_WIDTH-1:0] vga_out_q;
   logic [DATA_WIDTH-1:0] data_out_q;
   logic cfg_v_q, err_v_q, vga_v_q;
   logic err_seen_q;
   logic [1:0] last_q;

   logic cfg_acc, err_acc, vga_acc;
   logic pick_cfg;
   logic grant_cfg, grant_err, grant_vga;
   logic idle;
   logic busy;

`ifdef CM_SCHED_RR_EN
   // rr_q = 0 favours cfg, 1 favours vga
   logic rr_q;
`endif

   assign cfg_acc = cfg_valid & cfg_rdy_q;
   assign err_acc = err_valid & err_rdy_q;
   assign vga_acc = vga_valid & vga_rdy_q;

   assign idle = (state_q == S_IDLE);

`ifdef CM_SCHED_RR_EN
   assign pick_cfg = cfg_full_q & (~vga_full_q | ~rr_q);
`else
   assign pick_cfg = cfg_full_q;
`endif

   assign grant_err = idle & err_full_q;
   assign grant_cfg = idle & ~err_full_q & pick_cfg;
   assign grant_vga = idle & ~err_full_q & ~pick_cfg & vga_full_q;

   // accept needs an empty register and grant a full one, so never both
   always_comb begin
      cfg_full_d = cfg_full_q;
      err_full_d = err_full_q;
      vga_full_d = vga_full_q;
      if (cfg_acc) cfg_full_d = 1'b1;
      else if (grant_cfg) cfg_full_d = 1'b0;
      if (err_acc) err_full_d = 1'b1;
      else if (grant_err) err_full_d = 1'b0;
      if (vga_acc) vga_full_d = 1'b1;
      else if (grant_vga) vga_full_d = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_IDLE;
         gap_cnt_q  <= '0;
         cfg_full_q <= 1'b0;
         err_full_q <= 1'b0;
         vga_full_q <= 1'b0;
         cfg_rdy_q  <= 1'b0;
         err_rdy_q  <= 1'b0;
         vga_rdy_q  <= 1'b0;
         cfg_code_q <= '0;
         err_code_q <= '0;
         vga_code_q <= '0;
         vga_data_q <= '0;
         cfg_out_q  <= '0;
         err_out_q  <= '0;
         vga_out_q  <= '0;
         data_out_q <= '0;
         cfg_v_q    <= 1'b0;
         err_v_q    <= 1'b0;
         vga_v_q    <= 1'b0;
         err_seen_q <= 1'b0;
         last_q     <= '0;
`ifdef CM_SCHED_RR_EN
         rr_q       <= 1'b0;
`endif
      end else begin
         cfg_full_q <= cfg_full_d;
         err_full_q <= err_full_d;
         vga_full_q <= vga_full_d;
         cfg_rdy_q  <= ~cfg_full_d;
         err_rdy_q  <= ~err_full_d;
         vga_rdy_q  <= ~vga_full_d;
         if (cfg_acc) cfg_code_q <= cfg_code;
         if (err_acc) err_code_q <= err_code;
         if (vga_acc) begin
            vga_code_q <= vga_code;
            vga_data_q <= vga_data;
         end
         cfg_v_q <= 1'b0;
         err_v_q <= 1'b0;
         vga_v_q <= 1'b0;
         // a grant on the same edge overrides the clear below
         if (err_clr) err_seen_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (grant_err) begin
                  err_v_q    <= 1'b1;
                  err_out_q  <= err_code_q;
                  err_seen_q <= 1'b1;
                  last_q     <= SRC_ERR;
               end else if (grant_cfg) begin
                  cfg_v_q   <= 1'b1;
                  cfg_out_q <= cfg_code_q;
                  last_q    <= SRC_CFG;
`ifdef CM_SCHED_RR_EN
                  rr_q      <= 1'b1;
`endif
               end else if (grant_vga) begin
                  vga_v_q    <= 1'b1;
                  vga_out_q  <= vga_code_q;
                  data_out_q <= vga_data_q;
                  last_q     <= SRC_VGA;
`ifdef CM_SCHED_RR_EN
                  rr_q       <= 1'b0;
`endif
               end
               if ((grant_err | grant_cfg | grant_vga) && GAP_CYCLES != 0) begin
                  state_q   <= S_GAP;
                  gap_cnt_q <= GAP_LOAD;
               end
            end
            S_GAP: begin
               if (gap_cnt_q == 4'd0) state_q <= S_IDLE;
               else gap_cnt_q <= gap_cnt_q - 4'd1;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign busy = cfg_full_q | err_full_q | vga_full_q | (state_q == S_GAP) |
                 cfg_v_q | err_v_q | vga_v_q;

   always_comb begin
      Config_Status      = '0;
      Config_Status[0]   = busy;
      Config_Status[1]   = err_seen_q;
      Config_Status[3:2] = last_q;
   end

   assign cfg_ready                 = cfg_rdy_q;
   assign err_ready                 = err_rdy_q;
   assign vga_ready                 = vga_rdy_q;
   assign Config_Notification       = cfg_out_q;
   assign Config_Notification_Valid = cfg_v_q;
   assign Config_Error              = err_out_q;
   assign Error_Valid               = err_v_q;
   assign VGA_Notification          = vga_out_q;
   assign VGA_Notification_Valid    = vga_v_q;
   assign Data_VGA                  = data_out_q;

endmodule

// File: tb/tb_cm_event_scheduler.sv
// Directed bench for cm_event_scheduler: one instance with a 1-cycle gap,
// one with no gap, sharing the same request stimulus.
module tb_cm_event_scheduler;

`ifdef CM_SCHED_RR_EN
   localparam bit RR = 1'b1;
`else
   localparam bit RR = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst;
   logic cfg_valid, err_valid, vga_valid, err_clr;
   logic [3:0] cfg_code, err_code;
   logic [1:0] vga_code;
   logic [7:0] vga_data;

   logic cfg_ready, err_ready, vga_ready;
   logic [3:0] status, cn, ce;
   logic cn_v, ce_v, vn_v;
   logic [1:0] vn;
   logic [7:0] dv;

   logic cfg_ready_z, err_ready_z, vga_ready_z;
   logic [3:0] status_z, cn_z, ce_z;
   logic cn_v_z, ce_v_z, vn_v_z;
   logic [1:0] vn_z;
   logic [7:0] dv_z;

   int checks = 0;
   int failures = 0;
   int overlap = 0;
   int overlap_z = 0;
   int vga_pulses = 0;

   always #5 clk = ~clk;

   cm_event_scheduler #(.GAP_CYCLES(1)) dut (
      .clk(clk), .rst(rst),
      .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_code(cfg_code),
      .err_valid(err_valid), .err_ready(err_ready), .err_code(err_code),
      .vga_valid(vga_valid), .vga_ready(vga_ready), .vga_code(vga_code),
      .vga_data(vga_data), .err_clr(err_clr), .Config_Status(status),
      .Config_Notification(cn), .Config_Notification_Valid(cn_v),
      .Config_Error(ce), .Error_Valid(ce_v),
      .VGA_Notification(vn), .VGA_Notification_Valid(vn_v),
      .Data_VGA(dv)
   );

   cm_event_scheduler #(.GAP_CYCLES(0)) dut_z (
      .clk(clk), .rst(rst),
      .cfg_valid(cfg_valid), .cfg_ready(cfg_ready_z), .cfg_code(cfg_code),
      .err_valid(err_valid), .err_ready(err_ready_z), .err_code(err_code),
      .vga_valid(vga_valid), .vga_ready(vga_ready_z), .vga_code(vga_code),
      .vga_data(vga_data), .err_clr(err_clr), .Config_Status(status_z),
      .Config_Notification(cn_z), .Config_Notification_Valid(cn_v_z),
      .Config_Error(ce_z), .Error_Valid(ce_v_z),
      .VGA_Notification(vn_z), .VGA_Notification_Valid(vn_v_z),
      .Data_VGA(dv_z)
   );

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      if (int'(cn_v) + int'(ce_v) + int'(vn_v) > 1) overlap++;
      if (int'(cn_v_z) + int'(ce_v_z) + int'(vn_v_z) > 1) overlap_z++;
      if (vn_v) vga_pulses++;
   endtask

   initial begin
      int g;
      int snap;
      logic [1:0] src;
      logic [1:0] exp_src;

      rst = 1'b1;
      err_clr = 1'b0;
      cfg_valid = 1'b1; cfg_code = 4'hF;
      err_valid = 1'b1; err_code = 4'hF;
      vga_valid = 1'b1; vga_code = 2'h3; vga_data = 8'hFF;

      for (int i = 0; i < 3; i++) begin
         tick();
         chk("rst_outs", {cn_v, ce_v, vn_v, status, cn, ce, vn, dv}, 32'h0);
      end
      rst = 1'b0;
      cfg_valid = 1'b0; err_valid = 1'b0; vga_valid = 1'b0;
      tick();
      chk("rst_ready", {cfg_ready, err_ready, vga_ready}, 32'h7);
      chk("rst_status", status, 32'h0);

      // single vga request
      vga_valid = 1'b1; vga_code = 2'd2; vga_data = 8'hA5;
      tick();
      vga_valid = 1'b0;
      chk("vga_acc_rdy", vga_ready, 32'h0);
      chk("vga_acc_v", {cn_v, ce_v, vn_v}, 32'h0);
      tick();
      chk("vga_pulse", {cn_v, ce_v, vn_v}, 32'h1);
      chk("vga_code", vn, 32'h2);
      chk("vga_data", dv, 32'hA5);
      chk("vga_last", status[3:2], 32'h3);
      chk("vga_rdy_back", vga_ready, 32'h1);
      tick();
      chk("vga_after", {cn_v, ce_v, vn_v}, 32'h0);
      chk("vga_hold", dv, 32'hA5);
      chk("vga_idle_st", status, 32'hC);

      // three-way collision
      cfg_valid = 1'b1; cfg_code = 4'h5;
      err_valid = 1'b1; err_code = 4'h9;
      vga_valid = 1'b1; vga_code = 2'd1; vga_data = 8'h3C;
      tick();
      cfg_valid = 1'b0; err_valid = 1'b0; vga_valid = 1'b0;
      tick();
      chk("col_p1", {cn_v, ce_v, vn_v}, 32'h2);
      chk("col_ecode", ce, 32'h9);
      chk("col_eseen", status[1], 32'h1);
      tick();
      chk("col_gap1", {cn_v, ce_v, vn_v}, 32'h0);
      tick();
      chk("col_p2", {cn_v, ce_v, vn_v}, 32'h4);
      chk("col_ccode", cn, 32'h5);
      tick();
      chk("col_gap2", {cn_v, ce_v, vn_v}, 32'h0);
      tick();
      chk("col_p3", {cn_v, ce_v, vn_v}, 32'h1);
      chk("col_vcode", {vn, dv}, 32'h13C);
      tick();
      chk("col_end_st", status, 32'hE);
      err_clr = 1'b1;
      tick();
      err_clr = 1'b0;
      chk("col_clr_st", status, 32'hC);

      // fairness between cfg and vga
      cfg_valid = 1'b1; cfg_code = 4'h3;
      vga_valid = 1'b1; vga_code = 2'd2; vga_data = 8'h11;
      g = 0;
      for (int t = 0; t < 60 && g < 10; t++) begin
         tick();
         if (cn_v || vn_v) begin
            src = cn_v ? 2'd1 : 2'd3;
            exp_src = (RR && (g % 2 == 1)) ? 2'd3 : 2'd1;
            chk("fair_src", src, exp_src);
            g++;
         end
      end
      chk("fair_cnt", g, 10);
      cfg_valid = 1'b0; vga_valid = 1'b0;
      for (int i = 0; i < 12; i++) tick();

      // reset while in the gap with a vga request pending
      err_valid = 1'b1; err_code = 4'h4;
      vga_valid = 1'b1; vga_code = 2'd3; vga_data = 8'h77;
      tick();
      err_valid = 1'b0; vga_valid = 1'b0;
      tick();
      chk("rg_err", {cn_v, ce_v, vn_v}, 32'h2);
      snap = vga_pulses;
      rst = 1'b1;
      tick();
      chk("rg_status", status, 32'h0);
      chk("rg_valids", {cn_v, ce_v, vn_v}, 32'h0);
      chk("rg_status_z", status_z, 32'h0);
      tick();
      rst = 1'b0;
      for (int i = 0; i < 4; i++) tick();
      chk("rg_no_vga", vga_pulses - snap, 32'h0);
      chk("rg_ready", {cfg_ready, err_ready, vga_ready}, 32'h7);

      // zero-gap instance: err then cfg back to back
      err_valid = 1'b1; err_code = 4'h6;
      cfg_valid = 1'b1; cfg_code = 4'hA;
      tick();
      err_valid = 1'b0; cfg_valid = 1'b0;
      tick();
      chk("z_p1", {cn_v_z, ce_v_z, vn_v_z}, 32'h2);
      chk("z_ecode", ce_z, 32'h6);
      tick();
      chk("z_p2", {cn_v_z, ce_v_z, vn_v_z}, 32'h4);
      chk("z_ccode", cn_z, 32'hA);
      tick();
      chk("z_after", {cn_v_z, ce_v_z, vn_v_z}, 32'h0);

      chk("onehot", overlap, 32'h0);
      chk("onehot_z", overlap_z, 32'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/cm_event_scheduler.md
# cm_event_scheduler

Output-side controller for the configuration manager (CM). It accepts event requests from three internal producers (configuration FSM, error checker, VGA path) and serialises them onto the CM output ports, so that at most one of Config_Notification_Valid, Error_Valid and VGA_Notification_Valid is high in any cycle, with a programmable quiet gap after each pulse. It also owns the Config_Status output: busy, sticky error and last-granted source.

## Interface
- CONFIG_STATUS_WIDTH, 4: width of Config_Status; must be ≥4.
- CONFIG_NOTIFICATION_WIDTH, 4: config notification code width.
- CONFIG_ERROR_WIDTH, 4: error code width.
- VGA_NOTIFICATION_WIDTH, 2: VGA notification code width.
- DATA_WIDTH, 8: VGA data width.
- GAP_CYCLES, 1: idle cycles forced after every output pulse; 0 to 15.

- clk  in  1  clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- cfg_valid / cfg_ready / cfg_code  in / out / in  1 / 1 / CONFIG_NOTIFICATION_WIDTH  config notification request.
- err_valid / err_ready / err_code  in / out / in  1 / 1 / CONFIG_ERROR_WIDTH  error request.
- vga_valid / vga_ready / vga_code / vga_data  in / out / in / in  1 / 1 / VGA_NOTIFICATION_WIDTH / DATA_WIDTH  VGA notification request.
- err_clr  in  1  clears the sticky error status bit.
- Config_Status  out  CONFIG_STATUS_WIDTH  [0] busy, [1] error_seen, [3:2] last source (0 none, 1 cfg, 2 err, 3 vga), upper bits 0.
- Config_Notification, Config_Notification_Valid  out  CONFIG_NOTIFICATION_WIDTH, 1.
- Config_Error, Error_Valid  out  CONFIG_ERROR_WIDTH, 1.
- VGA_Notification, VGA_Notification_Valid  out  VGA_NOTIFICATION_WIDTH, 1.
- Data_VGA  out  DATA_WIDTH.

## Operation
- One single-entry holding register per source. ready = holding register empty (registered). Accept on valid && ready at a clock edge. No bypass: a full register cannot be refilled in the cycle it is granted.
- FSM states: IDLE, GAP.
  - IDLE: if any holding register is full, grant one. On the same edge:
    - load the matching output code.
    - pulse its Valid for exactly one cycle.
    - free that holding register.
    - go to GAP, or stay in IDLE if GAP_CYCLES = 0.
  - GAP: count GAP_CYCLES cycles with no Valid, then return to IDLE.
- Arbitration: err always wins. Between cfg and vga, the policy is set by the configuration macro (see Configuration).
- Code outputs and Data_VGA hold their last granted values between pulses. Data_VGA and VGA_Notification change only on a vga grant.
- Config_Status:
  - busy = any holding register full, or state = GAP, or a Valid is currently high.
  - error_seen is set on an err grant and cleared by err_clr. If both occur on the same edge, set wins.
  - last source is updated on every grant.
- Reset: all Valids 0, all codes and Data_VGA 0, Config_Status 0, holding registers empty, all ready = 1 in the cycle after reset deasserts, state IDLE, round-robin pointer favours cfg. Reset asserted mid-operation (including in GAP) discards pending requests without emitting a pulse.

## Timing
- Latency: a request accepted at edge k into an idle scheduler with no competitors produces its Valid high during the cycle after edge k+1.
- A ready dropped at accept edge k rises again in the cycle after that source's grant edge.
- Pulse spacing: consecutive Valids are separated by exactly GAP_CYCLES low cycles when requests are pending. With GAP_CYCLES = 0, Valids can be high back to back on different sources.
- Simultaneous requests from all three sources at edge k:
  - err pulses first.
  - The remaining two follow in arbitration order.
  - Each pulse is spaced by the gap.

## Configuration
- CM_SCHED_RR_EN defined: cfg and vga share round-robin. The pointer moves to the other source after a cfg or vga grant. err grants do not move the pointer.
- CM_SCHED_RR_EN undefined: fixed priority err > cfg > vga. A continuously requesting cfg can starve vga.

## Test plan
- Reset check: hold rst 3 cycles with all requests high. All outputs are 0 throughout. ready = 1 on all three sources one cycle after rst falls.
- Single vga request: vga_code = 2, vga_data = 0xA5 accepted at edge k. VGA_Notification_Valid is high only in the cycle after edge k+1, with VGA_Notification = 2 and Data_VGA = 0xA5. Config_Status[3:2] = 3.
- Three-way collision (GAP_CYCLES = 1): cfg, err and vga all valid on the same edge. Pulse order is err, cfg, vga, each separated by exactly 1 idle cycle. Config_Status[1] = 1 until err_clr is asserted.
- Fairness with CM_SCHED_RR_EN: cfg and vga held valid continuously for 10 grants. Grants alternate cfg, vga, cfg, … Without the macro, all 10 grants go to cfg.
- Reset mid-gap: assert rst during GAP while a vga request is held. No VGA_Notification_Valid pulse is emitted, and Config_Status = 0 in the cycle after the reset edge.
- GAP_CYCLES = 0 back-to-back: err and cfg requests pending. Error_Valid and Config_Notification_Valid are high in two consecutive cycles and are never high in the same cycle.
